// File: rtl/cap_sense_pkg.sv
// Shared types and default timing for the capacitive pad sequencer.
package cap_sense_pkg;

    localparam int COUNT_W = 32;

    localparam int DEF_DISCH_CYCLES   = 64;
    localparam int DEF_CHARGE_CYCLES  = 64;
    localparam int DEF_TIMEOUT_CYCLES = 100000;
    localparam int DEF_GAP_CYCLES     = 1000;
    localparam int DEF_THRESHOLD      = 200;
    localparam int DEF_DEBOUNCE       = 3;

    typedef logic [COUNT_W-1:0] count_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DISCHARGE = 3'd1,
        ST_CHARGE    = 3'd2,
        ST_WAIT      = 3'd3,
        ST_LATCH     = 3'd4,
        ST_EVAL      = 3'd5,
        ST_GAP       = 3'd6
    } state_t;

endpackage

// File: rtl/cap_sense_driver_debounce.sv
// Debounce of the raw touch decision: touched flips only after DEBOUNCE
// consecutive evaluations that disagree with it.
module touch_debounce
    import cap_sense_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_eval,
    input  logic i_raw,
    output logic o_touched
);

    localparam int CNT_W = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_touched;

    // Agreement counter and touched state, advanced once per evaluation.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_touched <= 1'b0;
        end else if (i_eval) begin
            if (i_raw == r_touched) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE - 1)) begin
                r_touched <= ~r_touched;
                r_cnt     <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_touched = r_touched;

endmodule

// File: rtl/cap_sense_driver.sv
// Excitation/evaluation sequencer for one capacitive touch pad.
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | pad held low, waiting for enable
// DISCHARGE | pad driven low for DISCH_CYCLES
// CHARGE    | pad driven high for CHARGE_CYCLES
// WAIT      | pad released, counter armed, waiting for pad to fall
// LATCH     | one cycle for the counter's final_count to settle
// EVAL      | sample captured, baseline/touch decision made
// GAP       | pad held low for GAP_CYCLES before the next measurement
module cap_sense_driver
    import cap_sense_pkg::*;
#(
    parameter int DISCH_CYCLES   = DEF_DISCH_CYCLES,
    parameter int CHARGE_CYCLES  = DEF_CHARGE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int THRESHOLD      = DEF_THRESHOLD,
    parameter int DEBOUNCE       = DEF_DEBOUNCE
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               sensor_in,
    input  logic [COUNT_W-1:0] meas_count,
    output logic               sensor_oe,
    output logic               sensor_drive,
    output logic               sensor_start,
    output logic               capacitor_charged,
    output logic               sample_valid,
    output logic [COUNT_W-1:0] sample,
    output logic [COUNT_W-1:0] baseline,
    output logic               touched,
    output logic               timeout
);

    state_t r_state;
    state_t w_next_state;
    count_t r_timer;
    count_t w_reload;
    logic   w_timer_done;
    logic   w_wait_timeout;

    logic   r_oe;
    logic   r_drive;
    logic   r_start;
    logic   r_charged;
    logic   w_oe;
    logic   w_drive;
    logic   w_start;
    logic   w_charged;

    logic   r_sample_valid;
    count_t r_sample;
    count_t r_baseline;
    logic   r_base_valid;
    logic   r_timeout;
    logic   w_touch_raw;
    logic   w_eval_strobe;
    logic   w_touched;

    assign w_timer_done   = (r_timer == '0);
    assign w_wait_timeout = (r_state == ST_WAIT) && sensor_in && w_timer_done;

    // Next-state decision for the measurement sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      if (enable) w_next_state = ST_DISCHARGE;
            ST_DISCHARGE: if (w_timer_done) w_next_state = ST_CHARGE;
            ST_CHARGE:    if (w_timer_done) w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (!sensor_in)        w_next_state = ST_LATCH;
                else if (w_timer_done) w_next_state = ST_GAP;
            end
            ST_LATCH:     w_next_state = ST_EVAL;
            ST_EVAL:      w_next_state = ST_GAP;
            ST_GAP: begin
                if (w_timer_done) w_next_state = enable ? ST_DISCHARGE : ST_IDLE;
            end
            default:      w_next_state = ST_IDLE;
        endcase
    end

    // Phase length loaded into the shared timer on entry to each timed state.
    always_comb begin
        w_reload = '0;
        case (w_next_state)
            ST_DISCHARGE: w_reload = COUNT_W'(DISCH_CYCLES - 1);
            ST_CHARGE:    w_reload = COUNT_W'(CHARGE_CYCLES - 1);
            ST_WAIT:      w_reload = COUNT_W'(TIMEOUT_CYCLES - 1);
            ST_GAP:       w_reload = COUNT_W'(GAP_CYCLES - 1);
            default:      w_reload = '0;
        endcase
    end

    // Pad outputs decoded from the next state so the registers line up with r_state.
    always_comb begin
        w_oe      = 1'b1;
        w_drive   = 1'b0;
        w_start   = 1'b0;
        w_charged = 1'b0;
        case (w_next_state)
            ST_CHARGE: w_drive = 1'b1;
            ST_WAIT, ST_LATCH, ST_EVAL: begin
                w_oe      = 1'b0;
                w_start   = 1'b1;
                w_charged = 1'b1;
            end
            default: ;
        endcase
    end

    // State register, shared phase timer and registered pad outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_oe      <= 1'b1;
            r_drive   <= 1'b0;
            r_start   <= 1'b0;
            r_charged <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_oe      <= w_oe;
            r_drive   <= w_drive;
            r_start   <= w_start;
            r_charged <= w_charged;
            if (w_next_state != r_state) begin
                r_timer <= w_reload;
            end else if (!w_timer_done) begin
                r_timer <= r_timer - COUNT_W'(1);
            end
        end
    end

    // Touch test widened by one bit so baseline + THRESHOLD cannot wrap.
    assign w_touch_raw   = ({1'b0, r_sample} > ({1'b0, r_baseline} + 33'(THRESHOLD)));
    assign w_eval_strobe = (r_state == ST_EVAL) && r_base_valid;

    // Sample capture, baseline learning and sticky timeout flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sample_valid <= 1'b0;
            r_sample       <= '0;
            r_baseline     <= '0;
            r_base_valid   <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_sample_valid <= (w_next_state == ST_EVAL);
            if (r_state == ST_LATCH) begin
                r_sample <= meas_count;
            end
            if (r_state == ST_EVAL) begin
                if (!r_base_valid) begin
                    r_baseline   <= r_sample;
                    r_base_valid <= 1'b1;
                end else if (!w_touched && (r_sample < r_baseline)) begin
                    r_baseline <= r_sample;
                end
            end
            if (w_wait_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    touch_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_eval    (w_eval_strobe),
        .i_raw     (w_touch_raw),
        .o_touched (w_touched)
    );

    assign sensor_oe         = r_oe;
    assign sensor_drive      = r_drive;
    assign sensor_start      = r_start;
    assign capacitor_charged = r_charged;
    assign sample_valid      = r_sample_valid;
    assign sample            = r_sample;
    assign baseline          = r_baseline;
    assign touched           = w_touched;
    assign timeout           = r_timeout;

endmodule

// File: tb/tb_cap_sense_driver.sv
// Directed bench: pad model plus discharge-counter model around cap_sense_driver.
module tb_cap_sense_driver;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        sensor_in;
    logic [31:0] meas_count;
    logic        sensor_oe;
    logic        sensor_drive;
    logic        sensor_start;
    logic        capacitor_charged;
    logic        sample_valid;
    logic [31:0] sample;
    logic [31:0] baseline;
    logic        touched;
    logic        timeout;

    int checks = 0;
    int errors = 0;
    int sv_count = 0;

    int          pad_delay;
    int          pad_cnt;
    logic [31:0] cnt_model;

    cap_sense_driver #(
        .DISCH_CYCLES   (4),
        .CHARGE_CYCLES  (8),
        .TIMEOUT_CYCLES (1000),
        .GAP_CYCLES     (16),
        .THRESHOLD      (50),
        .DEBOUNCE       (3)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .sensor_in         (sensor_in),
        .meas_count        (meas_count),
        .sensor_oe         (sensor_oe),
        .sensor_drive      (sensor_drive),
        .sensor_start      (sensor_start),
        .capacitor_charged (capacitor_charged),
        .sample_valid      (sample_valid),
        .sample            (sample),
        .baseline          (baseline),
        .touched           (touched),
        .timeout           (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pad stays high for pad_delay released cycles; counter counts armed-and-high cycles.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            pad_cnt   <= 0;
            cnt_model <= '0;
        end else begin
            if (sensor_oe) pad_cnt <= 0;
            else           pad_cnt <= pad_cnt + 1;
            if (!sensor_start)  cnt_model <= '0;
            else if (sensor_in) cnt_model <= cnt_model + 32'd1;
        end
    end

    assign sensor_in  = !(!sensor_oe && (pad_cnt >= pad_delay));
    assign meas_count = cnt_model;

    always @(posedge clock) if (sample_valid) sv_count <= sv_count + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Waits for the next sample_valid, checking latency from pad release and pulse width.
    task automatic wait_sample(input int d, input string tag);
        int   rel;
        logic prev_oe;
        logic found;
        rel     = 0;
        found   = 1'b0;
        prev_oe = sensor_oe;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick();
            if (prev_oe && !sensor_oe) rel = 1;
            else if (rel != 0)         rel++;
            prev_oe = sensor_oe;
            if (sample_valid) found = 1'b1;
        end
        check({tag, "_seen"}, 32'(found), 32'd1);
        check({tag, "_lat"}, rel, d + 3);
        check({tag, "_sample"}, sample, d);
        tick();
        check({tag, "_pulse"}, 32'(sample_valid), 32'd0);
    endtask

    task automatic meas(input int d, input int exp_base, input logic exp_touch, input string tag);
        pad_delay = d;
        wait_sample(d, tag);
        check({tag, "_base"}, baseline, exp_base);
        check({tag, "_touch"}, 32'(touched), 32'(exp_touch));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_oe"}, 32'(sensor_oe), 32'd1);
        check({tag, "_drive"}, 32'(sensor_drive), 32'd0);
        check({tag, "_start"}, 32'(sensor_start), 32'd0);
        check({tag, "_charged"}, 32'(capacitor_charged), 32'd0);
        check({tag, "_sv"}, 32'(sample_valid), 32'd0);
        check({tag, "_sample"}, sample, 32'd0);
        check({tag, "_base"}, baseline, 32'd0);
        check({tag, "_touch"}, 32'(touched), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        int   n;
        int   sv_before;
        logic found;

        reset     = 1'b1;
        enable    = 1'b0;
        pad_delay = 300;
        tick();
        tick();
        check_reset_values("rst");
        reset = 1'b0;
        repeat (3) tick();
        check("idle_oe", 32'(sensor_oe), 32'd1);
        check("idle_drive", 32'(sensor_drive), 32'd0);

        // First measurement: phase lengths, release edge and sample latency.
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && !sensor_drive; i++) begin
            tick();
            n++;
        end
        check("disch_len", n, 5);
        n = 0;
        for (int i = 0; i < 20 && sensor_drive; i++) begin
            tick();
            n++;
        end
        check("charge_len", n, 8);
        check("release_oe", 32'(sensor_oe), 32'd0);
        check("release_start", 32'(sensor_start), 32'd1);
        check("release_charged", 32'(capacitor_charged), 32'd1);
        n = 1;
        for (int i = 0; i < 2000 && !sample_valid; i++) begin
            tick();
            n++;
        end
        check("m1_lat", n, 303);
        check("m1_sample", sample, 32'd300);
        tick();
        check("m1_pulse", 32'(sample_valid), 32'd0);
        check("m1_base", baseline, 32'd300);
        check("m1_touch", 32'(touched), 32'd0);

        // Untouched samples: baseline tracks the minimum.
        meas(290, 290, 1'b0, "u290");
        meas(310, 290, 1'b0, "u310");

        // Exactly baseline + THRESHOLD is not a touch.
        meas(340, 290, 1'b0, "edge1");
        meas(340, 290, 1'b0, "edge2");
        meas(340, 290, 1'b0, "edge3");

        // Three touch samples set touched, three quiet ones clear it.
        meas(400, 290, 1'b0, "t1");
        meas(400, 290, 1'b0, "t2");
        meas(400, 290, 1'b1, "t3");
        meas(300, 290, 1'b1, "r1");
        meas(300, 290, 1'b1, "r2");
        meas(300, 290, 1'b0, "r3");

        // Interrupted touch run restarts the debounce count.
        meas(400, 290, 1'b0, "p1");
        meas(300, 290, 1'b0, "p2");
        meas(400, 290, 1'b0, "p3");
        meas(400, 290, 1'b0, "p4");
        meas(400, 290, 1'b1, "p5");

        // Pad never discharges: timeout on the last wait cycle, no sample.
        pad_delay = 5000;
        sv_before = sv_count;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (!sensor_oe) found = 1'b1;
        end
        check("to_release", 32'(found), 32'd1);
        n = 1;
        for (int i = 0; i < 1200 && !timeout; i++) begin
            tick();
            n++;
        end
        check("to_cycle", n, 1001);
        check("to_flag", 32'(timeout), 32'd1);
        check("to_gap_oe", 32'(sensor_oe), 32'd1);
        check("to_no_sv", sv_count - sv_before, 0);
        meas(300, 290, 1'b1, "retry");
        check("retry_timeout", 32'(timeout), 32'd1);

        // Reset mid-CHARGE aborts at once; baseline relearned afterwards.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (sensor_drive) found = 1'b1;
        end
        check("chg_seen", 32'(found), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        tick();
        reset = 1'b0;
        meas(320, 320, 1'b0, "post_rst");
        check("post_rst_timeout", 32'(timeout), 32'd0);

        // Enable dropped: current gap finishes and the FSM parks in IDLE.
        enable = 1'b0;
        sv_before = sv_count;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (sensor_drive) n++;
        end
        check("idle_no_charge", n, 0);
        check("idle_no_sv", sv_count - sv_before, 0);
        check("idle_start", 32'(sensor_start), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
